// File: rtl/micro_ctrl_fsm_pkg.sv
// Shared constants for the Fibonacci microprocessor control path.
// Holds the ALU opcode set, major opcodes, instruction field positions,
// the control FSM state type and the ALU opcode legality check.
package micro_ctrl_fsm_pkg;

  // ALU opcodes; 0111 and 1100-1111 are unassigned
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_EQ   = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  // Major opcodes
  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_I    = 4'h1;
  localparam logic [3:0] OP_BR   = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field bit positions
  localparam int F_MAJ_MSB = 31;
  localparam int F_MAJ_LSB = 28;
  localparam int F_OP_MSB  = 27;
  localparam int F_OP_LSB  = 24;
  localparam int F_RD_MSB  = 23;
  localparam int F_RD_LSB  = 20;
  localparam int F_RS1_MSB = 19;
  localparam int F_RS1_LSB = 16;
  localparam int F_RS2_MSB = 15;
  localparam int F_RS2_LSB = 12;
  localparam int F_IMM_MSB = 11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_e;

  function automatic logic alu_op_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_EQ,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/micro_instr_decode.sv
// Combinational instruction decoder: splits a 32-bit instruction word into
// its fields, sign-extends the 12-bit immediate and flags illegal encodings.
// Ports:
//   instr_i   instruction word
//   major_o   major opcode [31:28]
//   alu_op_o  ALU opcode [27:24]
//   rd_o      destination register [23:20]
//   rs1_o     first source register [19:16]
//   rs2_o     second source register [15:12]
//   imm_o     sign-extended [11:0]
//   legal_o   1 when major and (where relevant) alu_op are defined
module micro_instr_decode
  import micro_ctrl_fsm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       instr_i,
  output logic [3:0]        major_o,
  output logic [3:0]        alu_op_o,
  output logic [3:0]        rd_o,
  output logic [3:0]        rs1_o,
  output logic [3:0]        rs2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              legal_o
);

  assign major_o  = instr_i[F_MAJ_MSB:F_MAJ_LSB];
  assign alu_op_o = instr_i[F_OP_MSB:F_OP_LSB];
  assign rd_o     = instr_i[F_RD_MSB:F_RD_LSB];
  assign rs1_o    = instr_i[F_RS1_MSB:F_RS1_LSB];
  assign rs2_o    = instr_i[F_RS2_MSB:F_RS2_LSB];
  assign imm_o    = {{(DATA_W-12){instr_i[F_IMM_MSB]}}, instr_i[F_IMM_MSB:0]};

  // JMP and HALT ignore the alu_op field, so any value there is accepted
  always_comb begin
    legal_o = 1'b0;
    case (major_o)
      OP_R, OP_I, OP_BR: legal_o = alu_op_legal(alu_op_o);
      OP_JMP, OP_HALT:   legal_o = 1'b1;
      default:           legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/micro_ctrl_fsm.sv
// Multi-cycle control unit: fetches instructions over a variable-latency
// handshake, decodes them, drives ALU and register-file controls and
// resolves branches/jumps from the ALU result.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 leaves IDLE (ignored elsewhere)
//   imem_req/addr         fetch request and word address (FETCH only)
//   imem_valid/rdata      fetch response, honoured only in FETCH
//   alu_op/alu_src_imm    ALU controls, meaningful in EXECUTE
//   imm                   sign-extended immediate of the current instruction
//   alu_result            combinational ALU output, bit 0 decides branches
//   rf_ra1/ra2/wa/we      register-file addresses and write enable
//   pc, halted, illegal   program counter and sticky status
//   retired               saturating retired-instruction count
module micro_ctrl_fsm
  import micro_ctrl_fsm_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] alu_result,
  output logic [3:0]        rf_ra1,
  output logic [3:0]        rf_ra2,
  output logic [3:0]        rf_wa,
  output logic              rf_we,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       retired
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     retired_q, retired_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;

  logic [3:0]        dec_major, dec_op, dec_rd, dec_rs1, dec_rs2;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_legal;

  // Only bit 0 of the ALU result steers control flow
  logic unused_alu_hi;
  assign unused_alu_hi = ^alu_result[DATA_W-1:1];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  micro_instr_decode #(.DATA_W(DATA_W)) u_dec (
    .instr_i  (ir_q),
    .major_o  (dec_major),
    .alu_op_o (dec_op),
    .rd_o     (dec_rd),
    .rs1_o    (dec_rs1),
    .rs2_o    (dec_rs2),
    .imm_o    (dec_imm),
    .legal_o  (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    retired_d   = retired_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    imem_req    = 1'b0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!dec_legal) begin
          state_d   = HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else if (dec_major == OP_HALT) begin
          state_d   = HALT;
          halted_d  = 1'b1;
          retired_d = sat_inc(retired_q);
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        case (dec_major)
          OP_R: begin
            alu_op  = dec_op;
            state_d = WRITEBACK;
          end
          OP_I: begin
            alu_op      = dec_op;
            alu_src_imm = 1'b1;
            state_d     = WRITEBACK;
          end
          OP_BR: begin
            alu_op    = dec_op;
            pc_d      = alu_result[0] ? pc_q + dec_imm[PC_W-1:0] : pc_q + PC_W'(1);
            retired_d = sat_inc(retired_q);
            state_d   = FETCH;
          end
          OP_JMP: begin
            pc_d      = dec_imm[PC_W-1:0];
            retired_d = sat_inc(retired_q);
            state_d   = FETCH;
          end
          // DECODE filters every other major value; park safely if reached
          default: begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
        endcase
      end
      WRITEBACK: begin
        // r0 is hardwired to zero, so writes to it are suppressed
        rf_we     = (dec_rd != 4'd0);
        pc_d      = pc_q + PC_W'(1);
        retired_d = sat_inc(retired_q);
        state_d   = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_addr = imem_req ? pc_q : '0;
  assign imm       = dec_imm;
  assign rf_ra1    = dec_rs1;
  assign rf_ra2    = dec_rs2;
  assign rf_wa     = dec_rd;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_micro_ctrl_fsm.sv
module tb_micro_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic [31:0] alu_result = 32'd0;
  logic [3:0]  rf_ra1, rf_ra2, rf_wa;
  logic        rf_we;
  logic [7:0]  pc;
  logic        halted, illegal;
  logic [31:0] retired;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int c0     = 0;

  // Expected register-file writes, pushed when an instruction is issued
  logic [3:0] wb_q[$];

  always #5 clk = ~clk;

  micro_ctrl_fsm #(.DATA_W(32), .PC_W(8), .RESET_PC(8'd0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm(imm),
    .alu_result(alu_result),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we),
    .pc(pc), .halted(halted), .illegal(illegal), .retired(retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Every write-enable pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rf_we) begin
      chk("wb_pending", 32'(wb_q.size() > 0), 32'd1);
      if (wb_q.size() > 0) chk("rf_wa", 32'(rf_wa), 32'(wb_q.pop_front()));
    end
  end

  // Drives one fetch with lat wait cycles; returns in DECODE
  task automatic fetch_decode(input logic [31:0] ins, input int lat, input logic [7:0] addr);
    for (int i = 0; i < lat; i++) begin
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", 32'(imem_addr), 32'(addr));
      tick();
    end
    chk("req", 32'(imem_req), 32'd1);
    chk("addr", 32'(imem_addr), 32'(addr));
    imem_valid = 1'b1;
    imem_rdata = ins;
    tick();
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    chk("req_drop", 32'(imem_req), 32'd0);
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!imem_req && n < 16);
    chk("fetch_reached", 32'(imem_req), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    imem_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_wa", 32'(rf_wa), 32'd0);

    // ADDI r1,r0,5 at zero fetch latency: 4 cycles
    do_start();
    wb_q.push_back(4'd1);
    fetch_decode(32'h1010_0005, 0, 8'd0);
    tick();
    chk("addi_op", 32'(alu_op), 32'h0);
    chk("addi_src", 32'(alu_src_imm), 32'd1);
    chk("addi_imm", imm, 32'd5);
    alu_result = 32'd5;
    wait_fetch();
    chk("addi_lat", 32'(cyc - c0), 32'd4);
    chk("addi_pc", 32'(pc), 32'd1);
    chk("addi_ret", retired, 32'd1);

    // ADD r3,r1,r2 with 3 wait cycles: 7 cycles
    c0 = cyc;
    wb_q.push_back(4'd3);
    fetch_decode(32'h0031_2000, 3, 8'd1);
    chk("add_ra1", 32'(rf_ra1), 32'd1);
    chk("add_ra2", 32'(rf_ra2), 32'd2);
    chk("add_wa", 32'(rf_wa), 32'd3);
    tick();
    chk("add_op", 32'(alu_op), 32'h0);
    chk("add_src", 32'(alu_src_imm), 32'd0);
    wait_fetch();
    chk("add_lat", 32'(cyc - c0), 32'd7);
    chk("add_pc", 32'(pc), 32'd2);
    chk("add_ret", retired, 32'd2);

    // JMP 5, then taken branch -2 lands at 3
    c0 = cyc;
    fetch_decode(32'h3000_0005, 0, 8'd2);
    wait_fetch();
    chk("jmp_lat", 32'(cyc - c0), 32'd3);
    chk("jmp5_pc", 32'(pc), 32'd5);
    c0 = cyc;
    fetch_decode(32'h2501_2FFE, 0, 8'd5);
    tick();
    alu_result = 32'd1;
    chk("br_op", 32'(alu_op), 32'h5);
    chk("br_src", 32'(alu_src_imm), 32'd0);
    chk("br_imm", imm, 32'hFFFF_FFFE);
    wait_fetch();
    alu_result = 32'd0;
    chk("br_lat", 32'(cyc - c0), 32'd3);
    chk("br_taken_pc", 32'(pc), 32'd3);
    chk("br_taken_ret", retired, 32'd4);

    // JMP 5, then not-taken branch falls through to 6
    fetch_decode(32'h3000_0005, 0, 8'd3);
    wait_fetch();
    fetch_decode(32'h2501_2FFE, 0, 8'd5);
    tick();
    alu_result = 32'd0;
    wait_fetch();
    chk("br_nt_pc", 32'(pc), 32'd6);
    chk("br_nt_ret", retired, 32'd6);

    // JMP 0x10, JMP 0xFF, ADDI at 0xFF wraps to 0
    fetch_decode(32'h3000_0010, 0, 8'd6);
    wait_fetch();
    chk("jmp10_pc", 32'(pc), 32'h10);
    fetch_decode(32'h3000_00FF, 0, 8'h10);
    tick();
    chk("jmpff_imm", imm, 32'h0000_00FF);
    wait_fetch();
    chk("jmpff_pc", 32'(pc), 32'hFF);
    wb_q.push_back(4'd1);
    fetch_decode(32'h1010_0005, 0, 8'hFF);
    wait_fetch();
    chk("wrap_up_pc", 32'(pc), 32'h00);
    chk("wrap_up_ret", retired, 32'd9);

    // Branch -1 from 0 wraps down to 0xFF
    fetch_decode(32'h2501_2FFF, 0, 8'h00);
    tick();
    alu_result = 32'd1;
    wait_fetch();
    alu_result = 32'd0;
    chk("wrap_dn_pc", 32'(pc), 32'hFF);

    // ADD r0: retires with no write enable
    fetch_decode(32'h0001_2000, 0, 8'hFF);
    wait_fetch();
    chk("r0_pc", 32'(pc), 32'h00);
    chk("r0_ret", retired, 32'd11);

    // Illegal alu_op 0111 halts with retired unchanged
    fetch_decode(32'h0731_2000, 0, 8'h00);
    tick();
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_illegal", 32'(illegal), 32'd1);
    chk("ill_ret", retired, 32'd11);
    chk("ill_req", 32'(imem_req), 32'd0);
    start = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h1010_0005;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    chk("halt_abs_req", 32'(imem_req), 32'd0);
    chk("halt_abs_halted", 32'(halted), 32'd1);
    chk("halt_abs_pc", 32'(pc), 32'h00);
    chk("halt_abs_ret", retired, 32'd11);

    // Reset during FETCH discards a late response
    do_reset();
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_illegal", 32'(illegal), 32'd0);
    do_start();
    chk("rst2_fetch_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h1010_0005;
    tick();
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    chk("late_req", 32'(imem_req), 32'd0);
    chk("late_pc", 32'(pc), 32'd0);
    chk("late_imm", imm, 32'd0);
    chk("late_wa", 32'(rf_wa), 32'd0);
    tick();
    chk("late_idle_req", 32'(imem_req), 32'd0);
    chk("late_ret", retired, 32'd0);

    // HALT instruction retires and halts without illegal
    do_start();
    fetch_decode(32'hF000_0000, 1, 8'd0);
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_illegal", 32'(illegal), 32'd0);
    chk("halt_ret", retired, 32'd1);

    tick();
    chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
